// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared widths, FSM states and command magnitude helper
package motor_pkg;

  localparam int DUTY_W = 10;
  localparam int CMD_W  = 11;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 10'h3FF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DECEL = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // Two's-complement magnitude; -1024 has no positive twin and clamps to DUTY_MAX.
  function automatic logic [DUTY_W-1:0] sat_abs(input logic signed [CMD_W-1:0] v);
    logic [CMD_W-1:0] u;
    logic [CMD_W-1:0] mag;
    u   = v;
    mag = u[CMD_W-1] ? (~u + 11'd1) : u;
    if (mag > {1'b0, DUTY_MAX}) begin
      return DUTY_MAX;
    end
    return mag[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/motor_duty_ramp_slew_step.sv
// rtl/motor_duty_ramp_slew_step.sv - one slew-limited step of cur toward goal
module slew_step
  import motor_pkg::*;
#(
  parameter int STEP = 16
) (
  input  logic [DUTY_W-1:0] cur_i,
  input  logic [DUTY_W-1:0] goal_i,
  output logic [DUTY_W-1:0] nxt_o
);

  localparam logic [CMD_W-1:0] STEP_W = CMD_W'(STEP);

  logic [CMD_W-1:0] cur_w;
  logic [CMD_W-1:0] goal_w;
  logic [CMD_W-1:0] up_w;
  logic [CMD_W-1:0] dn_w;
  logic [CMD_W-1:0] lim_w;

  // One spare bit keeps cur+STEP and goal+STEP from wrapping near full scale.
  always_comb begin
    cur_w  = {1'b0, cur_i};
    goal_w = {1'b0, goal_i};
    up_w   = cur_w + STEP_W;
    dn_w   = cur_w - STEP_W;
    lim_w  = goal_w + STEP_W;
    nxt_o  = cur_i;
    if (cur_w < goal_w) begin
      nxt_o = (up_w < goal_w) ? up_w[DUTY_W-1:0] : goal_i;
    end else if (cur_w > goal_w) begin
      nxt_o = (cur_w > lim_w) ? dn_w[DUTY_W-1:0] : goal_i;
    end
  end

endmodule

// File: rtl/motor_duty_ramp.sv
// rtl/motor_duty_ramp.sv - period-aligned slew-limited duty with safe direction reversal
module motor_duty_ramp
  import motor_pkg::*;
#(
  parameter int STEP         = 16,
  parameter int HOLD_PERIODS = 2,
  parameter int PERIOD_BITS  = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [CMD_W-1:0]  cmd,
  input  logic                     cmd_vld,
  input  logic                     en,
  output logic [DUTY_W-1:0]        duty,
  output logic                     dir,
  output logic                     period_strb,
  output logic                     at_target,
  output logic                     rev_busy
);

  localparam int HC_W = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_PERIODS - 1);

  logic [PERIOD_BITS-1:0] pcnt_q, pcnt_d;
  logic [DUTY_W-1:0]      duty_q;
  logic                   dir_q;
  logic [DUTY_W-1:0]      tgt_mag_q, tgt_mag_d;
  logic                   tgt_dir_q, tgt_dir_d;
  logic [HC_W-1:0]        hold_cnt_q;
  state_e                 state_q;

  logic                   strobe;
  logic                   dir_match;
  logic                   hold_done;
  logic [DUTY_W-1:0]      goal_mag;
  logic [DUTY_W-1:0]      slew_nxt;

  assign strobe    = &pcnt_q;
  assign dir_match = (dir_q == tgt_dir_q);
  assign hold_done = (hold_cnt_q == HOLD_LAST);

  // The goal is the target only when the move ends facing the target direction.
  always_comb begin
    goal_mag = '0;
    if (state_q != IDLE && (dir_match || (state_q == HOLD && hold_done))) begin
      goal_mag = tgt_mag_q;
    end
  end

  always_comb begin
    pcnt_d    = pcnt_q + 1'b1;
    tgt_mag_d = tgt_mag_q;
    tgt_dir_d = tgt_dir_q;
    if (cmd_vld) begin
      tgt_mag_d = sat_abs(cmd);
      if (cmd != '0) begin
        tgt_dir_d = cmd[CMD_W-1];
      end
    end
  end

  slew_step #(.STEP(STEP)) u_slew (
    .cur_i  (duty_q),
    .goal_i (goal_mag),
    .nxt_o  (slew_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt_q     <= '0;
      duty_q     <= '0;
      dir_q      <= 1'b0;
      tgt_mag_q  <= '0;
      tgt_dir_q  <= 1'b0;
      hold_cnt_q <= '0;
      state_q    <= IDLE;
    end else begin
      pcnt_q    <= pcnt_d;
      tgt_mag_q <= tgt_mag_d;
      tgt_dir_q <= tgt_dir_d;
      if (!en) begin
        duty_q     <= '0;
        hold_cnt_q <= '0;
        state_q    <= IDLE;
      end else begin
        case (state_q)
          IDLE: state_q <= RUN;
          RUN: begin
            if (strobe) begin
              duty_q <= slew_nxt;
              if (!dir_match) begin
                hold_cnt_q <= '0;
                state_q    <= (slew_nxt == '0) ? HOLD : DECEL;
              end
            end
          end
          DECEL: begin
            if (strobe) begin
              duty_q <= slew_nxt;
              if (dir_match) begin
                state_q <= RUN;
              end else if (slew_nxt == '0) begin
                hold_cnt_q <= '0;
                state_q    <= HOLD;
              end
            end
          end
          HOLD: begin
            if (strobe) begin
              if (dir_match || hold_done) begin
                dir_q   <= tgt_dir_q;
                duty_q  <= slew_nxt;
                state_q <= RUN;
              end else begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign duty        = duty_q;
  assign dir         = dir_q;
  assign period_strb = strobe;
  assign at_target   = (state_q == RUN) && (duty_q == tgt_mag_q) && dir_match;
  assign rev_busy    = (state_q == DECEL) || (state_q == HOLD);

endmodule

// File: doc/motor_duty_ramp.md
Name: motor_duty_ramp

Overview:
Upstream companion to the 10-bit PWM generator. Converts a signed drive command into a slew-limited 10-bit duty magnitude plus a direction bit, with a safe reversal sequence. The sequence is: ramp to zero, hold at zero, then flip direction. Duty changes only at PWM period boundaries, so the downstream PWM never sees a mid-period change.

Parameters:
STEP, 16, maximum duty change per update (1..1023)
HOLD_PERIODS, 2, PWM periods held at duty 0 before a direction flip (minimum 1)
PERIOD_BITS, 10, period counter width; 2^PERIOD_BITS clocks per PWM period

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
cmd  input  11  signed requested drive, two's complement; -1024 saturates to -1023
cmd_vld  input  1  one-cycle qualifier; cmd captured on this edge
en  input  1  drive enable; low forces duty 0
duty  output  10  duty magnitude to the PWM block
dir  output  1  direction, 0 = forward, 1 = reverse
period_strb  output  1  high during the final clock of each period (pcnt == all ones)
at_target  output  1  RUN state with duty == target magnitude and dir == target direction
rev_busy  output  1  high while in DECEL or HOLD

Behaviour:
- Reset (sampled only on a clk edge): pcnt=0, duty=0, dir=0, tgt_mag=0, tgt_dir=0, hold_cnt=0, state=IDLE. All outputs are 0 except period_strb, which decodes pcnt.
- pcnt is free-running and wraps from 1023 to 0. It restarts from 0 after reset, which keeps it aligned with the PWM counter.
- Capture on cmd_vld:
  - tgt_mag = |cmd|, saturated to 1023.
  - tgt_dir = cmd[10] when cmd != 0.
  - cmd == 0 sets tgt_mag=0 and leaves tgt_dir unchanged.
- Update timing: duty, dir, state and hold_cnt change only on the edge that ends a period_strb cycle. The only exceptions are reset and en low. The new duty is therefore valid from pcnt == 0.
- Simultaneous cmd_vld and period_strb: the update uses the old target; the new target takes effect at the next strobe.
- Slew rule, with 11-bit internal arithmetic (no wrap):
  - If duty < goal: duty = min(duty+STEP, goal).
  - If duty > goal: duty = max(duty-STEP, goal).
- FSM states:
  - IDLE: duty=0. If en=1, next edge goes to RUN; duty stays 0 until the first strobe.
  - RUN, dir == tgt_dir: slew toward tgt_mag.
  - RUN, dir != tgt_dir: at the strobe, go to DECEL if duty != 0, else to HOLD (hold_cnt cleared).
  - DECEL: slew toward 0. When duty reaches 0, go to HOLD. If tgt_dir returns to dir, go to RUN at the next strobe and slew toward tgt_mag.
  - HOLD: duty=0; hold_cnt increments per strobe. On the strobe where hold_cnt reaches HOLD_PERIODS-1: dir <= tgt_dir, go to RUN. If tgt_dir == dir when a strobe arrives, go to RUN with no flip.
  - en low in any state: on the next edge (not strobe-gated), duty=0, state=IDLE, hold_cnt=0. dir is retained.
- Within one period, at most one STEP of duty change is applied.
- A reset mid-operation behaves identically to power-on reset.

Decomposition:
- Package motor_pkg holds:
  - DUTY_W=10, CMD_W=11, DUTY_MAX=10'h3FF
  - the state enum {IDLE, RUN, DECEL, HOLD}
  - the saturating-abs function
- One natural combinational sub-module, slew_step. Inputs: cur, goal, STEP. Output: next value.

Test Plan:
All scenarios use STEP=16 and HOLD_PERIODS=2.
1. Reset, en=1, cmd=+100 -> duty goes 16,32,48,64,80,96,100 on strobes 1..7, dir=0, at_target rises with 7th update.
2. From duty=100/dir=0, cmd=-50 -> DECEL 84,68,52,36,20,4,0; HOLD 2 periods at 0, rev_busy=1; then dir=1, duty 16,32,48,50, at_target=1.
3. cmd=-1024 -> tgt_mag=1023, dir flips to 1 after HOLD, duty ramps in 16s to 1023 (64 strobes from 0), never wraps.
4. In DECEL at duty=52, cmd=+70 -> state RUN next strobe, duty 68,70, dir stays 0, no HOLD.
5. Mid-ramp at duty=48, en=0 for 1 cycle at pcnt=500 -> duty=0 next edge, IDLE; en=1 restarts ramp from 0 at next strobe.
6. Two further checks:
   - rst_n=0 held across one edge at pcnt=500 -> all state cleared and pcnt=0.
   - cmd_vld at pcnt=1023 -> update uses the old target; the new target applies at the next strobe.
